esc_lpdt_deserializer: RTL and testbench
========================================

# esc_lpdt_deserializer

Receive-side escape-mode LPDT byte assembler for the C-PHY slave LP path. It sits directly downstream of the escape decoder and consumes its serial EscBit stream while low-power data transmission is active. It packs the bits into bytes, counts the bytes in each LPDT burst, and flags bursts that end or abort mid-byte. All logic runs on the recovered escape clock RxClkEsc.

## Interface
- CNT_W, 16: width of the per-burst byte counter.
- MSB_FIRST, 0: 0 means the first received bit is byte bit 0; 1 means it is bit 7.

Ports:
- RxClkEsc  in  1  recovered escape clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- RxLpdtEsc  in  1  LPDT mode active, from the escape decoder.
- EscBit  in  1  serial data bit, from the escape decoder.
- ErrEsc  in  1  escape-entry or sequence error, from the escape decoder.
- LpFsmStop  in  1  LP FSM returned to stop state, from the escape decoder.
- RxDataEsc  out  8  assembled byte; holds its value between valid pulses.
- RxValidEsc  out  1  one-cycle pulse: RxDataEsc holds a new byte.
- RxByteCnt  out  CNT_W  bytes completed in the current or last burst; saturates at all-ones.
- RxLpdtDone  out  1  one-cycle pulse when a burst terminates, whether clean or not.
- ErrLpdtPartial  out  1  sticky flag: the last burst ended with 1–7 leftover bits.

## Operation
- Bit qualifier: a rising edge of RxClkEsc with RxLpdtEsc=1, LpFsmStop=0 and ErrEsc=0 carries exactly one data bit on EscBit.
- Shift register: 8 bits wide. A 3-bit counter bitcnt tracks the position within the current byte.
- State IDLE:
  - On a qualifying bit, clear RxByteCnt and ErrLpdtPartial.
  - Store the bit, set bitcnt=1, and go to SHIFT.
- State SHIFT, on a qualifying bit:
  - Store the bit at position bitcnt, or 7-bitcnt when MSB_FIRST=1.
  - bitcnt increments and wraps from 7 to 0.
  - On the edge that stores the 8th bit: load the full byte into RxDataEsc, pulse RxValidEsc, and increment RxByteCnt (no change if already all-ones).
- State SHIFT, edge with RxLpdtEsc=0 (clean end):
  - Pulse RxLpdtDone.
  - If bitcnt≠0, set ErrLpdtPartial and discard the partial bits.
  - Go to IDLE.
- State SHIFT, edge with ErrEsc=1 or LpFsmStop=1:
  - Pulse RxLpdtDone and discard the partial bits.
  - Set ErrLpdtPartial if bitcnt≠0.
  - Go to ABORT.
- State ABORT:
  - Ignore EscBit.
  - Return to IDLE on the first edge with RxLpdtEsc=0 or LpFsmStop=1.
- Priority within one edge, highest first: ErrEsc/LpFsmStop, then RxLpdtEsc=0, then data bit.
  - Consequence: a byte whose 8th bit coincides with ErrEsc is discarded. There is no RxValidEsc pulse and the count is not incremented.
- In IDLE, ErrEsc and LpFsmStop are ignored. RxLpdtEsc=1 is required to leave IDLE.

## Timing
- Reset (RST=0, asynchronous) sets:
  - state IDLE, bitcnt 0, shift register 0x00
  - RxDataEsc 0x00, RxValidEsc 0, RxByteCnt 0, RxLpdtDone 0, ErrLpdtPartial 0
- Reset is honoured mid-burst: all partial data is lost. No Done pulse and no error flag are generated.
- Latency: RxValidEsc and RxDataEsc become valid on the same edge that samples the 8th bit. They stay valid until the next edge.
- RxValidEsc and RxLpdtDone are each exactly one RxClkEsc period wide.
  - The consumer must sample them with RxClkEsc. No ready/backpressure exists.
- RxByteCnt and ErrLpdtPartial are updated on the byte or termination edge and hold until the next burst starts.
- Back-to-back bursts: the burst start after an IDLE edge clears the counters on that same edge. The first bit of the new burst is not lost.
- Every output is registered. None has a combinational path from an input.

## Test plan
- Single byte, MSB_FIRST=0: bits 1,0,1,0,0,1,0,1 with RxLpdtEsc high, then RxLpdtEsc low -> RxDataEsc=0xA5 with a one-cycle RxValidEsc on the 8th edge; RxByteCnt=1; one RxLpdtDone pulse; ErrLpdtPartial=0.
- Three bytes 0x01, 0xFF, 0x3C continuous -> three RxValidEsc pulses exactly 8 edges apart with matching data; RxByteCnt=3. With MSB_FIRST=1 and the same bit stream -> 0x80, 0xFF, 0x3C.
- Partial burst: one full byte 0x5A, then 5 bits, then RxLpdtEsc low -> one valid pulse (0x5A); ErrLpdtPartial=1; RxByteCnt=1; Done pulse. A following clean 1-byte burst -> ErrLpdtPartial cleared, RxByteCnt=1.
- Abort on the 8th bit of byte 2, with ErrEsc high on that edge -> only byte 1 is reported; RxByteCnt=1; ErrLpdtPartial=1; state ABORT. Bits driven while in ABORT produce no output. RxLpdtEsc low -> IDLE.
- Counter saturation, CNT_W=2, five-byte burst -> RxByteCnt goes 1, 2, 3, 3, 3; all five RxValidEsc pulses still occur.
- Reset mid-byte: assert RST=0 after 4 bits -> all outputs return to reset values immediately with no clock edge. Release RST, send byte 0xC3 -> it is assembled correctly from its first bit.

Source files
------------

// File: rtl/esc_lpdt_deserializer.sv
// esc_lpdt_deserializer
// Receive-side escape-mode LPDT byte assembler. Consumes the serial EscBit
// stream from the escape decoder, packs it into bytes, counts the bytes of
// each burst and flags bursts that terminate with a partial byte pending.
// Everything runs on the recovered escape clock RxClkEsc.

module esc_lpdt_deserializer #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             RxClkEsc,
    input  logic             RST,
    input  logic             RxLpdtEsc,
    input  logic             EscBit,
    input  logic             ErrEsc,
    input  logic             LpFsmStop,
    output logic [7:0]       RxDataEsc,
    output logic             RxValidEsc,
    output logic [CNT_W-1:0] RxByteCnt,
    output logic             RxLpdtDone,
    output logic             ErrLpdtPartial
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BCNT_W  = 3;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [BCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0]   shift_q,  shift_d;
    logic [BYTE_W-1:0]   data_q,   data_d;
    logic                valid_q,  valid_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;

    logic                bit_ok_c;
    logic                abort_c;
    logic [BCNT_W-1:0]   bit_pos_c;
    logic [BYTE_W-1:0]   shift_ins_c;
    logic [BYTE_W-1:0]   shift_first_c;
    logic [CNT_W-1:0]    cnt_inc_c;

    // Edge qualifiers: a data bit only when LPDT is active and no error/stop
    always_comb begin
        bit_ok_c = RxLpdtEsc & ~LpFsmStop & ~ErrEsc;
        abort_c  = ErrEsc | LpFsmStop;
    end

    // Bit placement within the byte and saturating byte-count increment
    always_comb begin
        bit_pos_c = (MSB_FIRST != 0) ? BCNT_W'(LAST_BIT - bitcnt_q) : bitcnt_q;

        shift_ins_c            = shift_q;
        shift_ins_c[bit_pos_c] = EscBit;

        shift_first_c            = '0;
        shift_first_c[bit_pos_c] = EscBit;

        cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // Error and stop are ignored here; LPDT must be active to start
                if (bit_ok_c) begin
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    shift_d  = shift_first_c;
                    bitcnt_d = BCNT_W'(1);
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (abort_c) begin
                    // Abort wins even over a completing 8th bit
                    done_d   = 1'b1;
                    err_d    = (bitcnt_q != '0);
                    shift_d  = '0;
                    bitcnt_d = '0;
                    state_d  = ST_ABORT;
                end else if (!RxLpdtEsc) begin
                    done_d   = 1'b1;
                    err_d    = (bitcnt_q != '0);
                    shift_d  = '0;
                    bitcnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + BCNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        data_d  = shift_ins_c;
                        valid_d = 1'b1;
                        cnt_d   = cnt_inc_c;
                        shift_d = '0;
                    end else begin
                        shift_d = shift_ins_c;
                    end
                end
            end

            ST_ABORT: begin
                // Wait for the decoder to leave LPDT or return to stop
                if (!RxLpdtEsc || LpFsmStop) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                bitcnt_d = '0;
                shift_d  = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge RxClkEsc or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign RxDataEsc      = data_q;
    assign RxValidEsc     = valid_q;
    assign RxByteCnt      = cnt_q;
    assign RxLpdtDone     = done_q;
    assign ErrLpdtPartial = err_q;

endmodule

// File: tb/tb_esc_lpdt_deserializer.sv
// Directed bench for esc_lpdt_deserializer. Three instances share one
// stimulus stream: LSB-first/16-bit count, MSB-first, and a 2-bit count.

module tb_esc_lpdt_deserializer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic lpdt = 1'b0;
    logic esc_bit = 1'b0;
    logic err_esc = 1'b0;
    logic stop = 1'b0;

    logic [7:0]  d0_data, d1_data, d2_data;
    logic        d0_valid, d1_valid, d2_valid;
    logic [15:0] d0_cnt, d1_cnt;
    logic [1:0]  d2_cnt;
    logic        d0_done, d1_done, d2_done;
    logic        d0_err, d1_err, d2_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    esc_lpdt_deserializer #(.CNT_W(16), .MSB_FIRST(0)) dut_lsb (
        .RxClkEsc(clk), .RST(rst_n), .RxLpdtEsc(lpdt), .EscBit(esc_bit),
        .ErrEsc(err_esc), .LpFsmStop(stop), .RxDataEsc(d0_data),
        .RxValidEsc(d0_valid), .RxByteCnt(d0_cnt), .RxLpdtDone(d0_done),
        .ErrLpdtPartial(d0_err));

    esc_lpdt_deserializer #(.CNT_W(16), .MSB_FIRST(1)) dut_msb (
        .RxClkEsc(clk), .RST(rst_n), .RxLpdtEsc(lpdt), .EscBit(esc_bit),
        .ErrEsc(err_esc), .LpFsmStop(stop), .RxDataEsc(d1_data),
        .RxValidEsc(d1_valid), .RxByteCnt(d1_cnt), .RxLpdtDone(d1_done),
        .ErrLpdtPartial(d1_err));

    esc_lpdt_deserializer #(.CNT_W(2), .MSB_FIRST(0)) dut_sat (
        .RxClkEsc(clk), .RST(rst_n), .RxLpdtEsc(lpdt), .EscBit(esc_bit),
        .ErrEsc(err_esc), .LpFsmStop(stop), .RxDataEsc(d2_data),
        .RxValidEsc(d2_valid), .RxByteCnt(d2_cnt), .RxLpdtDone(d2_done),
        .ErrLpdtPartial(d2_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        lpdt = 1'b1; err_esc = 1'b0; stop = 1'b0; esc_bit = b;
        tick();
    endtask

    task automatic drive_end();
        lpdt = 1'b0; err_esc = 1'b0; stop = 1'b0; esc_bit = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (d0_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", d0_data); end
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", d0_valid); end
        total++; if (d0_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", d0_cnt); end
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", d0_done); end
        total++; if (d0_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", d0_err); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (d0_valid !== 1'b0 || d0_done !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b%b exp=00", d0_valid, d0_done); end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            total++;
            if (d0_valid !== (i == 7)) begin bad++; $display("FAIL single_valid bit=%0d got=%b exp=%b", i, d0_valid, (i == 7)); end
        end
        total++; if (d0_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", d0_data); end
        total++; if (d1_data !== 8'hA5) begin bad++; $display("FAIL single_data_msb got=%h exp=a5", d1_data); end
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", d0_cnt); end
        drive_end();
        total++; if (d0_done !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", d0_done); end
        total++; if (d1_done !== 1'b1 || d2_done !== 1'b1) begin bad++; $display("FAIL single_done_others got=%b%b exp=11", d1_done, d2_done); end
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL single_valid_width got=%b exp=0", d0_valid); end
        total++; if (d0_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", d0_err); end
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt_end got=%0d exp=1", d0_cnt); end
        drive_end();
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL single_done_width got=%b exp=0", d0_done); end
        total++; if (d0_data !== 8'hA5) begin bad++; $display("FAIL single_data_hold got=%h exp=a5", d0_data); end
    endtask

    task automatic test_multi_byte();
        logic [7:0] bytes   [3] = '{8'h01, 8'hFF, 8'h3C};
        logic [7:0] exp_msb [3] = '{8'h80, 8'hFF, 8'h3C};
        logic [1:0] exp_sat [3] = '{2'd1, 2'd2, 2'd3};
        logic [7:0] b;
        for (int e = 0; e < 24; e++) begin
            b = bytes[e / 8];
            drive_bit(b[e % 8]);
            total++;
            if (d0_valid !== ((e % 8) == 7) || d1_valid !== ((e % 8) == 7)) begin
                bad++; $display("FAIL multi_valid edge=%0d got=%b%b exp=%b", e, d0_valid, d1_valid, ((e % 8) == 7));
            end
            if ((e % 8) == 7) begin
                total++; if (d0_data !== bytes[e / 8]) begin bad++; $display("FAIL multi_data byte=%0d got=%h exp=%h", e / 8, d0_data, bytes[e / 8]); end
                total++; if (d1_data !== exp_msb[e / 8]) begin bad++; $display("FAIL multi_data_msb byte=%0d got=%h exp=%h", e / 8, d1_data, exp_msb[e / 8]); end
                total++; if (d0_cnt !== 16'(e / 8 + 1)) begin bad++; $display("FAIL multi_cnt byte=%0d got=%0d exp=%0d", e / 8, d0_cnt, e / 8 + 1); end
                total++; if (d2_cnt !== exp_sat[e / 8]) begin bad++; $display("FAIL multi_cnt_sat byte=%0d got=%0d exp=%0d", e / 8, d2_cnt, exp_sat[e / 8]); end
            end
        end
        drive_end();
        total++; if (d0_done !== 1'b1) begin bad++; $display("FAIL multi_done got=%b exp=1", d0_done); end
        total++; if (d0_cnt !== 16'd3 || d1_cnt !== 16'd3) begin bad++; $display("FAIL multi_cnt_end got=%0d/%0d exp=3", d0_cnt, d1_cnt); end
    endtask

    task automatic test_saturation();
        logic [7:0] bytes   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [7:0] b;
        for (int e = 0; e < 40; e++) begin
            b = bytes[e / 8];
            drive_bit(b[e % 8]);
            if ((e % 8) == 7) begin
                total++; if (d2_valid !== 1'b1) begin bad++; $display("FAIL sat_valid byte=%0d got=%b exp=1", e / 8, d2_valid); end
                total++; if (d2_data !== bytes[e / 8]) begin bad++; $display("FAIL sat_data byte=%0d got=%h exp=%h", e / 8, d2_data, bytes[e / 8]); end
                total++; if (d2_cnt !== exp_sat[e / 8]) begin bad++; $display("FAIL sat_cnt byte=%0d got=%0d exp=%0d", e / 8, d2_cnt, exp_sat[e / 8]); end
                total++; if (d0_cnt !== 16'(e / 8 + 1)) begin bad++; $display("FAIL sat_cnt_wide byte=%0d got=%0d exp=%0d", e / 8, d0_cnt, e / 8 + 1); end
            end
        end
        drive_end();
        total++; if (d2_done !== 1'b1 || d2_cnt !== 2'd3) begin bad++; $display("FAIL sat_end got=%b/%0d exp=1/3", d2_done, d2_cnt); end
    endtask

    task automatic test_partial();
        logic [7:0] b;
        logic [4:0] tail;
        b = 8'h5A;
        tail = 5'b01011;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        total++; if (d0_valid !== 1'b1 || d0_data !== 8'h5A) begin bad++; $display("FAIL partial_byte got=%b/%h exp=1/5a", d0_valid, d0_data); end
        for (int i = 0; i < 5; i++) begin
            drive_bit(tail[i]);
            total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL partial_tail_valid bit=%0d got=%b exp=0", i, d0_valid); end
        end
        drive_end();
        total++; if (d0_done !== 1'b1) begin bad++; $display("FAIL partial_done got=%b exp=1", d0_done); end
        total++; if (d0_err !== 1'b1 || d1_err !== 1'b1 || d2_err !== 1'b1) begin bad++; $display("FAIL partial_err got=%b%b%b exp=111", d0_err, d1_err, d2_err); end
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL partial_cnt got=%0d exp=1", d0_cnt); end
        total++; if (d0_data !== 8'h5A) begin bad++; $display("FAIL partial_data_hold got=%h exp=5a", d0_data); end
        // back-to-back clean burst starting on the very next edge
        b = 8'h11;
        drive_bit(b[0]);
        total++; if (d0_err !== 1'b0 || d0_cnt !== 16'd0) begin bad++; $display("FAIL b2b_clear got=%b/%0d exp=0/0", d0_err, d0_cnt); end
        for (int i = 1; i < 8; i++) drive_bit(b[i]);
        total++; if (d0_valid !== 1'b1 || d0_data !== 8'h11) begin bad++; $display("FAIL b2b_byte got=%b/%h exp=1/11", d0_valid, d0_data); end
        drive_end();
        total++; if (d0_err !== 1'b0 || d0_cnt !== 16'd1 || d0_done !== 1'b1) begin bad++; $display("FAIL b2b_end got=%b/%0d/%b exp=0/1/1", d0_err, d0_cnt, d0_done); end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        int seen;
        b = 8'h12;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        b = 8'h34;
        for (int i = 0; i < 7; i++) drive_bit(b[i]);
        lpdt = 1'b1; err_esc = 1'b1; esc_bit = b[7];
        tick();
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", d0_valid); end
        total++; if (d0_done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b exp=1", d0_done); end
        total++; if (d0_err !== 1'b1) begin bad++; $display("FAIL abort_err got=%b exp=1", d0_err); end
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d exp=1", d0_cnt); end
        total++; if (d0_data !== 8'h12) begin bad++; $display("FAIL abort_data got=%h exp=12", d0_data); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive_bit(1'(i & 1));
            if (d0_valid !== 1'b0 || d0_done !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_ignore got=%0d exp=0", seen); end
        total++; if (d0_cnt !== 16'd1 || d0_err !== 1'b1) begin bad++; $display("FAIL abort_hold got=%0d/%b exp=1/1", d0_cnt, d0_err); end
        drive_end();
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL abort_exit_done got=%b exp=0", d0_done); end
        b = 8'h96;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        total++; if (d0_valid !== 1'b1 || d0_data !== 8'h96 || d0_cnt !== 16'd1) begin bad++; $display("FAIL abort_recover got=%b/%h/%0d exp=1/96/1", d0_valid, d0_data, d0_cnt); end
        drive_end();
    endtask

    task automatic test_idle_ignore();
        logic [7:0] b;
        lpdt = 1'b1; err_esc = 1'b1; esc_bit = 1'b1;
        tick(); tick(); tick();
        err_esc = 1'b0; stop = 1'b1;
        tick(); tick(); tick();
        total++; if (d0_cnt !== 16'd1 || d0_done !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%0d/%b exp=1/0", d0_cnt, d0_done); end
        b = 8'h69;
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            total++;
            if (d0_valid !== (i == 7)) begin bad++; $display("FAIL idle_start_valid bit=%0d got=%b exp=%b", i, d0_valid, (i == 7)); end
        end
        total++; if (d0_data !== 8'h69) begin bad++; $display("FAIL idle_start_data got=%h exp=69", d0_data); end
        drive_end();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hFF;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (d0_data !== 8'h00 || d0_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_async got=%h/%0d exp=00/0", d0_data, d0_cnt); end
        total++; if (d0_valid !== 1'b0 || d0_done !== 1'b0 || d0_err !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b%b%b exp=000", d0_valid, d0_done, d0_err); end
        lpdt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (d0_done !== 1'b0 || d0_err !== 1'b0) begin bad++; $display("FAIL rstmid_nodone got=%b%b exp=00", d0_done, d0_err); end
        b = 8'hC3;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        total++; if (d0_valid !== 1'b1 || d0_data !== 8'hC3) begin bad++; $display("FAIL rstmid_byte got=%b/%h exp=1/c3", d0_valid, d0_data); end
        total++; if (d1_data !== 8'hC3 || d0_cnt !== 16'd1) begin bad++; $display("FAIL rstmid_msb_cnt got=%h/%0d exp=c3/1", d1_data, d0_cnt); end
        drive_end();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_saturation();
        test_partial();
        test_abort();
        test_idle_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
